adder_pipe: RTL and testbench

Parametrised, pipelined unsigned adder; the next generation of the team's 4-bit registered adder. Operand width and pipeline depth are configurable, carry-in/carry-out are exposed, and a valid/ready handshake on both sides gives full-throughput streaming with backpressure. It sits between an operand producer and a result consumer in datapath blocks, driven by the same interface-based benches as the existing adder.

---
 rtl/adder_pipe.sv | 103 ++++++++++
 tb/tb_adder_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined unsigned adder with valid/ready flow control: each stage adds one
// WIDTH/STAGES-bit segment. Define ADDER_PIPE_SAT_EN to saturate the result on carry-out.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int SEG = WIDTH / STAGES;

    logic [STAGES-1:0] r_full;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_opa [STAGES];
    logic [WIDTH-1:0]  r_opb [STAGES];

    logic [STAGES-1:0] w_ready;
    logic [STAGES-1:0] w_src_full;
    logic [STAGES-1:0] w_src_c;
    logic [WIDTH-1:0]  w_src_a    [STAGES];
    logic [WIDTH-1:0]  w_src_b    [STAGES];
    logic [WIDTH-1:0]  w_src_sum  [STAGES];
    logic [WIDTH-1:0]  w_sum_next [STAGES];
    logic [SEG:0]      w_seg      [STAGES];

    // Operands are shifted down one segment per stage, so every stage adds bits [SEG-1:0].
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_src_full[k] = in_valid;
            assign w_src_c[k]    = cin;
            assign w_src_a[k]    = in1;
            assign w_src_b[k]    = in2;
            assign w_src_sum[k]  = '0;
        end else begin : g_next
            assign w_src_full[k] = r_full[k-1];
            assign w_src_c[k]    = r_carry[k-1];
            assign w_src_a[k]    = r_opa[k-1];
            assign w_src_b[k]    = r_opb[k-1];
            assign w_src_sum[k]  = r_sum[k-1];
        end

        // A stage can load when it is empty or its content moves on this cycle.
        if (k == STAGES - 1) begin : g_last_ready
            assign w_ready[k] = !r_full[k] || out_ready;
        end else begin : g_mid_ready
            assign w_ready[k] = !r_full[k] || w_ready[k+1];
        end

        assign w_seg[k] = {1'b0, w_src_a[k][SEG-1:0]} + {1'b0, w_src_b[k][SEG-1:0]}
                        + (SEG+1)'(w_src_c[k]);
        assign w_sum_next[k] = w_src_sum[k] | (WIDTH'(w_seg[k][SEG-1:0]) << (k * SEG));
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset too, so out/cout read 0 after reset
            // and no value from a discarded transaction stays visible.
            for (int k = 0; k < STAGES; k++) begin
                r_full[k]  <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_opa[k]   <= '0;
                r_opb[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_full[k] <= w_src_full[k];
                    if (w_src_full[k]) begin
                        r_sum[k]   <= w_sum_next[k];
                        r_carry[k] <= w_seg[k][SEG];
                        r_opa[k]   <= w_src_a[k] >> SEG;
                        r_opb[k]   <= w_src_b[k] >> SEG;
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready[0] && !rst;
    assign out_valid = r_full[STAGES-1];
    assign cout      = r_carry[STAGES-1];

`ifdef ADDER_PIPE_SAT_EN
    assign out = r_carry[STAGES-1] ? '1 : r_sum[STAGES-1];
`else
    assign out = r_sum[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=8, STAGES=2): directed handshake
// scenarios plus random traffic scored against a queue-based reference of the sums.
module tb_adder_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout;

    int           total = 0;
    int           bad   = 0;
    int           n_emit = 0;
    logic [W:0]   q [$];
    logic [W-1:0] held_out;
    int           emit_mark;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected {cout, out} from plain integer arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
`ifdef ADDER_PIPE_SAT_EN
        if (s >= (1 << W)) s = (1 << W) | ((1 << W) - 1);
`endif
        return (W+1)'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move from posedge+1 to a point where inputs and outputs are settled.
    task automatic probe();
        #3;
    endtask

    // Score the handshakes happening at the coming edge, then cross it.
    task automatic advance();
        logic [W:0] e;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_emit++;
                check("emit_pending", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("sum_out", 32'(out), 32'(e[W-1:0]));
                    check("sum_cout", 32'(cout), 32'(e[W]));
                end
            end
            if (in_valid && in_ready) q.push_back(ref_sum(in1, in2, cin));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        probe();
        advance();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int n = 0; n < 40 && q.size() > 0; n++) tick();
        check("drain_empty", 32'(q.size()), 0);
        probe();
        check("drain_idle", 32'(out_valid), 0);
        advance();
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        cin = c;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in1 = W'($urandom); in2 = W'($urandom); cin = 1'b0;

        // Reset held for 3 cycles with in_valid high.
        advance();
        for (int i = 0; i < 3; i++) begin
            probe();
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_out", 32'(out), 0);
            check("rst_cout", 32'(cout), 0);
            check("rst_in_ready", 32'(in_ready), 0);
            advance();
        end
        rst = 1'b0; in_valid = 1'b0;
        advance();
        probe();
        check("post_rst_in_ready", 32'(in_ready), 1);
        advance();
        for (int i = 0; i < 3; i++) begin
            probe();
            check("post_rst_idle", 32'(out_valid), 0);
            advance();
        end

        // Basic add 200 + 100: result visible right after the second edge.
        drive(8'd200, 8'd100, 1'b0);
        probe();
        check("basic_in_ready", 32'(in_ready), 1);
        advance();
        in_valid = 1'b0;
        probe();
        check("basic_lat_early", 32'(out_valid), 0);
        advance();
        probe();
        check("basic_valid", 32'(out_valid), 1);
`ifdef ADDER_PIPE_SAT_EN
        check("basic_out", 32'(out), 255);
`else
        check("basic_out", 32'(out), 44);
`endif
        check("basic_cout", 32'(cout), 1);
        advance();

        drive(8'hFF, 8'h00, 1'b1);
        advance();
        in_valid = 1'b0;
        advance();
        probe();
`ifdef ADDER_PIPE_SAT_EN
        check("ff_plus_cin_out", 32'(out), 255);
`else
        check("ff_plus_cin_out", 32'(out), 0);
`endif
        check("ff_plus_cin_cout", 32'(cout), 1);
        advance();
        drain();

        // Streaming i + i back to back.
        for (int i = 0; i < 32; i++) begin
            drive(W'(i), W'(i), 1'b0);
            probe();
            check("stream_in_ready", 32'(in_ready), 1);
            if (i >= 2) begin
                check("stream_valid", 32'(out_valid), 1);
                check("stream_out", 32'(out), 32'(2 * (i - 2)));
            end
            advance();
        end
        drain();

        // Backpressure: three operands against a stalled consumer.
        out_ready = 1'b0;
        emit_mark = n_emit;
        drive(W'($urandom), W'($urandom), 1'($urandom));
        probe(); check("bp_acc1", 32'(in_ready), 1); advance();
        drive(W'($urandom), W'($urandom), 1'($urandom));
        probe(); check("bp_acc2", 32'(in_ready), 1); advance();
        drive(W'($urandom), W'($urandom), 1'($urandom));
        probe();
        check("bp_full_ready", 32'(in_ready), 0);
        check("bp_full_valid", 32'(out_valid), 1);
        held_out = out;
        advance();
        probe();
        check("bp_still_full", 32'(in_ready), 0);
        check("bp_out_held", 32'(out), 32'(held_out));
        advance();
        out_ready = 1'b1;
        probe();
        check("bp_release_ready", 32'(in_ready), 1);
        advance();
        drain();
        check("bp_emit_count", 32'(n_emit - emit_mark), 3);

        // Bubble compression: stage 0 accepts while the output is stalled.
        out_ready = 1'b0;
        drive(W'($urandom), W'($urandom), 1'($urandom));
        tick();
        in_valid = 1'b0;
        tick();
        drive(W'($urandom), W'($urandom), 1'($urandom));
        probe();
        check("bubble_accept", 32'(in_ready), 1);
        check("bubble_valid", 32'(out_valid), 1);
        advance();
        in_valid = 1'b0;
        probe();
        check("bubble_full", 32'(in_ready), 0);
        advance();
        drain();

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        drive(W'($urandom), W'($urandom), 1'($urandom));
        tick();
        drive(W'($urandom), W'($urandom), 1'($urandom));
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        probe();
        check("midrst_in_ready", 32'(in_ready), 0);
        advance();
        rst = 1'b0;
        probe();
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_out", 32'(out), 0);
        check("midrst_cout", 32'(cout), 0);
        check("midrst_in_ready_after", 32'(in_ready), 1);
        advance();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            probe();
            check("midrst_no_ghost", 32'(out_valid), 0);
            advance();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in1 = W'($urandom);
            in2 = W'($urandom);
            cin = 1'($urandom);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
